// File: rtl/ahb_lite_manager.sv
// AHB-Lite single-transfer manager: one command in flight, SINGLE bursts,
// registered bus outputs, local alignment reject and wait-state timeout.
module ahb_lite_manager #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic [1:0]            HRESP
);

  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic [1:0]            htrans_q, htrans_d;
  logic                  hwrite_q, hwrite_d;
  logic [2:0]            hsize_q, hsize_d;
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rerr_q, rerr_d;
  logic                  rto_q, rto_d;
  logic [7:0]            wait_q, wait_d;

  logic                  size_bad;
  logic                  misalign;
  logic                  reject;
  logic [ADDR_WIDTH-1:0] amask;
  logic [7:0]            wait_inc;
  logic                  to_hit;
  logic                  unused_hresp;

  assign unused_hresp = HRESP[1];

  assign amask    = ~({ADDR_WIDTH{1'b1}} << cmd_size);
  assign size_bad = cmd_size > 3'(MAX_SIZE);
  assign misalign = |(cmd_addr & amask);
  assign reject   = size_bad | misalign;
  assign wait_inc = wait_q + 8'd1;
  assign to_hit   = wait_inc == 8'(TIMEOUT_CYCLES);

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    htrans_d = htrans_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    hwdata_d = hwdata_q;
    wdata_d  = wdata_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    rto_d    = rto_q;
    wait_d   = wait_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (reject) begin
            rvalid_d = 1'b1;
            rerr_d   = 1'b1;
            rto_d    = 1'b0;
            rdata_d  = '0;
          end else begin
            state_d  = S_ADDR;
            haddr_d  = cmd_addr;
            hwrite_d = cmd_write;
            hsize_d  = cmd_size;
            htrans_d = T_NONSEQ;
            wdata_d  = cmd_wdata;
            wait_d   = '0;
          end
        end
      end
      S_ADDR, S_DATA: begin
        if (HREADY) begin
          htrans_d = T_IDLE;
          if (state_q == S_ADDR) begin
            state_d = S_DATA;
            if (hwrite_q) hwdata_d = wdata_q;
          end else begin
            state_d  = S_IDLE;
            rvalid_d = 1'b1;
            rerr_d   = HRESP[0];
            rto_d    = 1'b0;
            rdata_d  = hwrite_q ? '0 : HRDATA;
          end
        end else if (to_hit) begin
          // Subordinate stalled too long: give up and report
          state_d  = S_IDLE;
          htrans_d = T_IDLE;
          rvalid_d = 1'b1;
          rerr_d   = 1'b1;
          rto_d    = 1'b1;
          rdata_d  = '0;
          wait_d   = wait_inc;
        end else begin
          wait_d = wait_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      haddr_q  <= '0;
      htrans_q <= T_IDLE;
      hwrite_q <= 1'b0;
      hsize_q  <= '0;
      hwdata_q <= '0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      rto_q    <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      hwdata_q <= hwdata_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
      rto_q    <= rto_d;
      wait_q   <= wait_d;
    end
  end

  assign cmd_ready   = state_q == S_IDLE;
  assign rsp_valid   = rvalid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_error   = rerr_q;
  assign rsp_timeout = rto_q;
  assign HADDR       = haddr_q;
  assign HTRANS      = htrans_q;
  assign HWRITE      = hwrite_q;
  assign HSIZE       = hsize_q;
  assign HBURST      = 3'b000;
  assign HWDATA      = hwdata_q;

endmodule
